// File: rtl/edge_event_arbiter_if.sv
// Event port between the edge-event arbiter (master) and its single consumer (slave).
// The event is transferred when evt_valid && evt_ready at a rising clock edge.
interface edge_event_arbiter_if #(
  parameter int ID_W = 2
);
  logic            evt_valid;
  logic            evt_ready;
  logic [ID_W-1:0] evt_id;
  logic            evt_rise;

  modport master (output evt_valid, evt_id, evt_rise, input evt_ready);
  modport slave  (input evt_valid, evt_id, evt_rise, output evt_ready);
endinterface

// File: rtl/edge_event_arbiter.sv
// Per-channel rise/fall edge detection with pending-event storage, sticky overflow flags and
// round-robin serialisation of the pending events onto one valid/ready event port.
module edge_event_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         i_sig,
  input  logic [N-1:0]         i_rise_en,
  input  logic [N-1:0]         i_fall_en,
  input  logic [N-1:0]         i_ovf_clr,
  output logic [N-1:0]         o_ovf,
  edge_event_arbiter_if.master evt
);

  logic [N-1:0]    r_h0, r_h1;          // newest / previous sample of i_sig
  logic [N-1:0]    r_pend_r, r_pend_f;
  logic [N-1:0]    r_ord;               // 1: pending rise was detected before pending fall
  logic [N-1:0]    r_ovf;
  logic [ID_W-1:0] r_ptr;
  logic            r_valid;
  logic [ID_W-1:0] r_id;
  logic            r_rise;

  logic [N-1:0]    w_det_r, w_det_f, w_any;
  logic [N-1:0]    w_gnt_r, w_gnt_f, w_keep_r, w_keep_f;
  logic [N-1:0]    w_set_r, w_set_f, w_pend_r_nxt, w_pend_f_nxt;
  logic [N-1:0]    w_ord_nxt, w_ovf_set, w_oh;
  logic            w_load, w_found, w_rise_sel;
  logic [ID_W-1:0] w_win;
  int              w_best_d;

  assign w_det_r = r_h0 & ~r_h1 & i_rise_en;
  assign w_det_f = ~r_h0 & r_h1 & i_fall_en;
  assign w_any   = r_pend_r | r_pend_f;
  assign w_load  = ~r_valid | evt.evt_ready;

  // Round-robin pick: the pending channel closest after r_ptr (distance 0 == r_ptr+1).
  // NOTE: every always_comb output gets a default before any conditional write, so no latch forms.
  always_comb begin
    w_found    = 1'b0;
    w_win      = '0;
    w_rise_sel = 1'b0;
    w_oh       = '0;
    w_best_d   = N;
    for (int j = 0; j < N; j++) begin
      if (w_any[j] && (((j + N - 1 - int'(r_ptr)) % N) < w_best_d)) begin
        w_best_d   = (j + N - 1 - int'(r_ptr)) % N;
        w_found    = 1'b1;
        w_win      = ID_W'(j);
        w_rise_sel = r_pend_r[j] & (~r_pend_f[j] | r_ord[j]);
        w_oh       = '0;
        w_oh[j]    = 1'b1;
      end
    end
  end

  assign w_gnt_r  = (w_load && w_found &&  w_rise_sel) ? w_oh : '0;
  assign w_gnt_f  = (w_load && w_found && !w_rise_sel) ? w_oh : '0;
  assign w_keep_r = r_pend_r & ~w_gnt_r;
  assign w_keep_f = r_pend_f & ~w_gnt_f;

  // A detect on a still-pending bit is dropped; a bit granted this cycle can take the new event.
  assign w_set_r      = w_det_r & ~w_keep_r;
  assign w_set_f      = w_det_f & ~w_keep_f;
  assign w_ovf_set    = (w_det_r & w_keep_r) | (w_det_f & w_keep_f);
  assign w_pend_r_nxt = i_rise_en & (w_det_r | w_keep_r);
  assign w_pend_f_nxt = i_fall_en & (w_det_f | w_keep_f);
  assign w_ord_nxt    = (w_set_r & ~w_pend_f_nxt) | (w_set_f & w_pend_r_nxt) |
                        (~(w_set_r | w_set_f) & r_ord);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h0     <= '0;
      r_h1     <= '0;
      r_pend_r <= '0;
      r_pend_f <= '0;
      r_ord    <= '0;
      r_ovf    <= '0;
      r_ptr    <= ID_W'(N - 1);
      r_valid  <= 1'b0;
      r_id     <= '0;
      r_rise   <= 1'b0;
    end else begin
      r_h1     <= r_h0;
      r_h0     <= i_sig;
      r_pend_r <= w_pend_r_nxt;
      r_pend_f <= w_pend_f_nxt;
      r_ord    <= w_ord_nxt;
      r_ovf    <= (r_ovf & ~i_ovf_clr) | w_ovf_set;
      if (w_load) begin
        r_valid <= w_found;
        if (w_found) begin
          r_id   <= w_win;
          r_rise <= w_rise_sel;
          r_ptr  <= w_win;
        end
      end
    end
  end

  assign evt.evt_valid = r_valid;
  assign evt.evt_id    = r_id;
  assign evt.evt_rise  = r_rise;
  assign o_ovf         = r_ovf;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Randomised and directed bench for edge_event_arbiter: a queue-based reference model predicts
// each granted event into a scoreboard that a separate monitor drains on every handshake.
module tb_edge_event_arbiter;
  localparam int N    = 4;
  localparam int ID_W = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] sig, rise_en, fall_en, ovf_clr, ovf;

  edge_event_arbiter_if #(.ID_W(ID_W)) evt ();

  edge_event_arbiter #(.N(N), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_sig     (sig),
    .i_rise_en (rise_en),
    .i_fall_en (fall_en),
    .i_ovf_clr (ovf_clr),
    .o_ovf     (ovf),
    .evt       (evt)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each channel holds an ordered list of pending polarities (1 = rise),
  // at most one of each; arbitration walks channels after the last winner.
  typedef struct {
    int id;
    bit rise;
  } ev_t;

  ev_t          sb[$];
  bit           m_q [N][2];
  int           m_qn [N];
  bit [N-1:0]   m_new, m_old, m_ovf;
  int           m_ptr;
  bit           m_valid;
  bit           m_vis_valid;
  bit [N-1:0]   m_vis_ovf;
  bit           rot_chk = 1'b0;

  function automatic bit q_has(int c, bit pol);
    for (int k = 0; k < m_qn[c]; k++)
      if (m_q[c][k] == pol) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void q_remove(int c, bit pol);
    bit t [2];
    int n = 0;
    t[0] = 1'b0;
    t[1] = 1'b0;
    for (int k = 0; k < m_qn[c]; k++)
      if (m_q[c][k] != pol) begin
        t[n] = m_q[c][k];
        n++;
      end
    m_q[c][0] = t[0];
    m_q[c][1] = t[1];
    m_qn[c]   = n;
  endfunction

  function automatic void q_push(int c, bit pol);
    m_q[c][m_qn[c]] = pol;
    m_qn[c]++;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) m_qn[i] = 0;
    m_new       = '0;
    m_old       = '0;
    m_ovf       = '0;
    m_ptr       = N - 1;
    m_valid     = 1'b0;
    m_vis_valid = 1'b0;
    m_vis_ovf   = '0;
    sb.delete();
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  function automatic void model_step();
    bit [N-1:0] set_ovf = '0;
    int         c = -1;
    m_vis_valid = m_valid;
    m_vis_ovf   = m_ovf;
    if (!m_valid || evt.evt_ready) begin
      for (int k = 1; k <= N; k++)
        if (c < 0 && m_qn[(m_ptr + k) % N] > 0) c = (m_ptr + k) % N;
      if (c >= 0) begin
        sb.push_back('{c, m_q[c][0]});
        m_q[c][0] = m_q[c][1];
        m_qn[c]--;
        m_ptr   = c;
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!rise_en[i]) q_remove(i, 1'b1);
      if (!fall_en[i]) q_remove(i, 1'b0);
      if (rise_en[i] && m_new[i] && !m_old[i]) begin
        if (q_has(i, 1'b1)) set_ovf[i] = 1'b1;
        else q_push(i, 1'b1);
      end
      if (fall_en[i] && !m_new[i] && m_old[i]) begin
        if (q_has(i, 1'b0)) set_ovf[i] = 1'b1;
        else q_push(i, 1'b0);
      end
    end
    m_ovf = (m_ovf & ~ovf_clr) | set_ovf;
    m_old = m_new;
    m_new = sig;
  endfunction

  // Inputs are set at a falling edge; the model steps 1 time unit later.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      #1;
      if (rst) model_reset();
      else model_step();
      @(negedge clk);
    end
  endtask

  // Monitor: compares presented state every cycle and pops the scoreboard on each handshake.
  initial begin
    ev_t e;
    int  last_id;
    last_id = -1;
    forever begin
      @(negedge clk);
      #2;
      check("evt_valid", evt.evt_valid, m_vis_valid);
      check("ovf", ovf, m_vis_ovf);
      if (evt.evt_valid && evt.evt_ready && !rst) begin
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("evt_id", evt.evt_id, e.id);
          check("evt_rise", evt.evt_rise, e.rise);
          if (rot_chk) begin
            if (last_id >= 0) check("rr_rotate", evt.evt_id, (last_id + 1) % N);
            last_id = int'(evt.evt_id);
          end
        end
      end
      if (!rot_chk) last_id = -1;
    end
  end

  initial begin
    rst           = 1'b1;
    sig           = '0;
    rise_en       = '1;
    fall_en       = '1;
    ovf_clr       = '0;
    evt.evt_ready = 1'b1;
    model_reset();
    @(negedge clk);
    tick(3);
    check("reset_valid", evt.evt_valid, 0);
    check("reset_id", evt.evt_id, 0);
    check("reset_ovf", ovf, 0);
    rst = 1'b0;
    tick(3);

    // Three channels rise together: served 0, 1, 3 back to back.
    sig = 4'b1011;
    tick(8);
    // Single idle rise on channel 2.
    sig = 4'b1111;
    tick(6);
    sig = 4'b0000;
    tick(10);

    // Overflow on channel 1 while the slot is stalled.
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    evt.evt_ready = 1'b0;
    sig = 4'b0011;
    tick();
    sig = 4'b0001;
    tick();
    sig = 4'b0011;
    tick(4);
    check("ovf_set", ovf, 4'b0010);
    check("stall_valid", evt.evt_valid, 1);
    check("stall_id", evt.evt_id, 0);
    evt.evt_ready = 1'b1;
    tick(6);
    ovf_clr = 4'b0010;
    tick();
    ovf_clr = '0;
    check("ovf_cleared", ovf, 0);
    tick(2);

    // One-cycle pulse on channel 3 with falling events disabled.
    fall_en = 4'b0111;
    sig = 4'b1011;
    tick();
    sig = 4'b0011;
    tick(6);
    fall_en = '1;
    tick(2);

    // All channels toggling every cycle: grants must rotate.
    for (int i = 0; i < 40; i++) begin
      sig = ~sig;
      if (i == 8) rot_chk = 1'b1;
      tick();
    end
    rot_chk = 1'b0;
    sig = '0;
    tick(6);

    // Reset with events in flight and pending; channel 0 first afterwards.
    evt.evt_ready = 1'b0;
    sig = 4'b0111;
    tick();
    sig = 4'b1101;
    tick(3);
    rst = 1'b1;
    sig = '0;
    tick(2);
    check("rst_valid", evt.evt_valid, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
    tick(2);
    evt.evt_ready = 1'b1;
    sig = 4'b1111;
    tick(3);
    check("post_rst_valid", evt.evt_valid, 1);
    check("post_rst_id", evt.evt_id, 0);
    check("post_rst_rise", evt.evt_rise, 1);
    tick(8);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      sig           = sig ^ (N'($urandom) & N'($urandom));
      evt.evt_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0) rise_en = N'($urandom);
      if ($urandom_range(0, 31) == 0) fall_en = N'($urandom);
      ovf_clr = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      rst     = ($urandom_range(0, 299) == 0);
      tick();
    end

    rst           = 1'b0;
    rise_en       = '1;
    fall_en       = '1;
    ovf_clr       = '0;
    evt.evt_ready = 1'b1;
    tick(20);
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
